// File: rtl/aud_pkg.sv
// Shared audio definitions: recorder state encoding and the sample/address widths
// that the recorder and the playback DSP must agree on.
package aud_pkg;

    localparam int AUD_ADDR_W = 20;
    localparam int AUD_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_WRITE,
        S_PAUSE
    } rec_state_t;

endpackage

// File: rtl/aud_i2s_deser.sv
// I2S left-channel deserializer: detects the LRCK falling edge and shifts in
// DATA_W bits MSB first, starting one BCLK after that edge.
module aud_i2s_deser
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lrc,
    input  logic              data,
    input  logic              enable,
    input  logic              abort,
    output logic              lrc_fall,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic              lrc_d;
    logic              active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;

    // The edge cycle itself carries the previous slot's padding; capture starts next cycle.
    assign lrc_fall     = lrc_d && !lrc;
    assign sample_valid = active && (bit_cnt == LAST_BIT) && !abort;
    assign sample       = {shift[DATA_W-2:0], data};

    always_ff @(posedge clk) begin
        if (rst) begin
            lrc_d   <= 1'b1;
            active  <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            lrc_d <= lrc;
            if (abort) begin
                active  <= 1'b0;
                bit_cnt <= '0;
            end else if (active) begin
                shift <= sample;
                if (bit_cnt == LAST_BIT) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (enable && lrc_fall) begin
                active  <= 1'b1;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/aud_recorder.sv
// Audio recorder: captures left-channel I2S samples and writes them to SRAM
// sequentially from address 0, reporting the recorded length on o_stop_addr.
module aud_recorder
    import aud_pkg::*;
#(
    parameter int                ADDR_W   = AUD_ADDR_W,
    parameter int                DATA_W   = AUD_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_stop_addr,
    output logic              o_recording,
    output rec_state_t        o_state
);

    rec_state_t        state;
    logic              pause_pend;
    logic              lrc_fall;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              deser_enable;
    logic              deser_abort;

    assign o_state = state;

    // Arm the deserializer only when a falling edge would actually move us to CAPTURE.
    assign deser_enable = (state == S_WAIT) && !i_stop && !i_pause;
    assign deser_abort  = (state == S_CAPTURE) && i_stop;

    aud_i2s_deser #(
        .DATA_W(DATA_W)
    ) u_deser (
        .clk         (i_clk),
        .rst         (i_rst),
        .lrc         (i_lrc),
        .data        (i_data),
        .enable      (deser_enable),
        .abort       (deser_abort),
        .lrc_fall    (lrc_fall),
        .sample_valid(sample_valid),
        .sample      (sample)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_address   <= '0;
            o_data      <= '0;
            o_wr_en     <= 1'b0;
            o_stop_addr <= '0;
            o_recording <= 1'b0;
            pause_pend  <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        state       <= S_WAIT;
                        o_recording <= 1'b1;
                        o_address   <= '0;
                        o_stop_addr <= '0;
                        pause_pend  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_stop) begin
                        state       <= S_IDLE;
                        o_recording <= 1'b0;
                    end else if (i_pause) begin
                        state       <= S_PAUSE;
                        o_recording <= 1'b0;
                    end else if (lrc_fall) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (i_stop) begin
                        state       <= S_IDLE;
                        o_recording <= 1'b0;
                        pause_pend  <= 1'b0;
                    end else begin
                        if (i_pause) begin
                            pause_pend <= 1'b1;
                        end
                        if (sample_valid) begin
                            state   <= S_WRITE;
                            o_wr_en <= 1'b1;
                            o_data  <= sample;
                        end
                    end
                end
                S_WRITE: begin
                    o_stop_addr <= o_address + 1'b1;
                    pause_pend  <= 1'b0;
                    // The last address is held rather than wrapped so playback sees a sane bound.
                    if (o_address != MAX_ADDR) begin
                        o_address <= o_address + 1'b1;
                    end
                    if (o_address == MAX_ADDR || i_stop) begin
                        state       <= S_IDLE;
                        o_recording <= 1'b0;
                    end else if (pause_pend || i_pause) begin
                        state       <= S_PAUSE;
                        o_recording <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_PAUSE: begin
                    if (i_stop) begin
                        state <= S_IDLE;
                    end else if (!i_pause && i_start) begin
                        state       <= S_WAIT;
                        o_recording <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    o_recording <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: I2S frames driven cycle by cycle, write strobes
// logged per instance and compared against hand-computed addresses and samples.
module tb_aud_recorder;
    import aud_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_pause = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_lrc = 1'b1;
    logic        i_data = 1'b0;

    logic [19:0] o_address, m_address;
    logic [15:0] o_data, m_data;
    logic        o_wr_en, m_wr_en;
    logic [19:0] o_stop_addr, m_stop_addr;
    logic        o_recording, m_recording;
    rec_state_t  o_state, m_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [19:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    int          k_q[$];
    logic [19:0] ma_q[$];
    logic [15:0] md_q[$];

    always #5 clk = ~clk;

    aud_recorder dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause),
        .i_stop(i_stop), .i_lrc(i_lrc), .i_data(i_data),
        .o_address(o_address), .o_data(o_data), .o_wr_en(o_wr_en),
        .o_stop_addr(o_stop_addr), .o_recording(o_recording), .o_state(o_state)
    );

    aud_recorder #(.MAX_ADDR(20'd3)) dut_m (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause),
        .i_stop(i_stop), .i_lrc(i_lrc), .i_data(i_data),
        .o_address(m_address), .o_data(m_data), .o_wr_en(m_wr_en),
        .o_stop_addr(m_stop_addr), .o_recording(m_recording), .o_state(m_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic lrc, input logic d);
        i_lrc  = lrc;
        i_data = d;
        @(posedge clk);
        #1;
        cyc++;
        if (o_wr_en) begin
            wa_q.push_back(o_address);
            wd_q.push_back(o_data);
            wc_q.push_back(cyc);
        end
        if (m_wr_en) begin
            ma_q.push_back(m_address);
            md_q.push_back(m_data);
        end
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); k_q.delete();
        ma_q.delete(); md_q.delete();
    endtask

    // One I2S frame: fall cycle, 16 left bits, 3 idle left cycles, 20 right-channel cycles.
    task automatic frame(input logic [15:0] s, input int pause_at, input int stop_at, input int rst_at);
        k_q.push_back(cyc);
        step(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 16; i++) begin
            i_pause = (i == pause_at);
            i_stop  = (i == stop_at);
            i_rst   = (i == rst_at);
            step(1'b0, s[15-i]);
        end
        i_pause = 1'b0;
        i_stop  = 1'b0;
        i_rst   = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step(1'b1, 1'b0);
        i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        step(1'b1, 1'b0);
        i_stop = 1'b0;
    endtask

    initial begin
        logic [15:0] vec4 [4];
        logic [15:0] vecm [5];
        vec4 = '{16'h0001, 16'h8000, 16'hFFFF, 16'h7FFE};
        vecm = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 16'h0BAD};

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        i_rst = 1'b0;
        step(1'b1, 1'b0);
        check("rst_state", 32'(o_state), 32'(S_IDLE));
        check("rst_address", 32'(o_address), 32'h0);
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_wr_en", 32'(o_wr_en), 32'h0);
        check("rst_stop_addr", 32'(o_stop_addr), 32'h0);
        check("rst_recording", 32'(o_recording), 32'h0);

        // Single frame timing
        clear_log();
        pulse_start();
        check("start_state", 32'(o_state), 32'(S_WAIT));
        check("start_recording", 32'(o_recording), 32'h1);
        frame(16'hA5C3, -1, -1, -1);
        check("f1_count", 32'(wa_q.size()), 32'd1);
        check("f1_addr", 32'(wa_q[0]), 32'h0);
        check("f1_data", 32'(wd_q[0]), 32'hA5C3);
        check("f1_latency", 32'(wc_q[0] - k_q[0]), 32'd17);
        check("f1_stop_addr", 32'(o_stop_addr), 32'h1);
        check("f1_state", 32'(o_state), 32'(S_WAIT));

        // Four frames from a fresh start
        pulse_stop();
        pulse_start();
        clear_log();
        for (int i = 0; i < 4; i++) frame(vec4[i], -1, -1, -1);
        check("f4_count", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f4_addr%0d", i), 32'(wa_q[i]), 32'(i));
            check($sformatf("f4_data%0d", i), 32'(wd_q[i]), 32'(vec4[i]));
            check($sformatf("f4_lat%0d", i), 32'(wc_q[i] - k_q[i]), 32'd17);
        end
        check("f4_stop_addr", 32'(o_stop_addr), 32'h4);

        // Pause mid-frame completes the frame, then skips frames until restart
        pulse_stop();
        pulse_start();
        clear_log();
        frame(16'h1234, -1, -1, -1);
        frame(16'hBEEF, 5, -1, -1);
        check("pz_count", 32'(wa_q.size()), 32'd2);
        check("pz_addr", 32'(wa_q[1]), 32'h1);
        check("pz_data", 32'(wd_q[1]), 32'hBEEF);
        check("pz_state", 32'(o_state), 32'(S_PAUSE));
        check("pz_recording", 32'(o_recording), 32'h0);
        check("pz_stop_addr", 32'(o_stop_addr), 32'h2);
        for (int i = 0; i < 3; i++) frame(16'(i * 16'h1111 + 16'h0F00), -1, -1, -1);
        check("pz_skip_count", 32'(wa_q.size()), 32'd2);
        pulse_start();
        check("pz_resume_state", 32'(o_state), 32'(S_WAIT));
        frame(16'h4321, -1, -1, -1);
        check("pz_resume_addr", 32'(wa_q[2]), 32'h2);
        check("pz_resume_data", 32'(wd_q[2]), 32'h4321);

        // Stop mid-capture with 3 samples written
        frame(16'h5555, -1, 8, -1);
        check("stp_count", 32'(wa_q.size()), 32'd3);
        check("stp_state", 32'(o_state), 32'(S_IDLE));
        check("stp_stop_addr", 32'(o_stop_addr), 32'h3);
        check("stp_recording", 32'(o_recording), 32'h0);
        pulse_start();
        check("stp_restart_stop_addr", 32'(o_stop_addr), 32'h0);
        frame(16'h0F0F, -1, -1, -1);
        check("stp_restart_addr", 32'(wa_q[3]), 32'h0);
        check("stp_restart_data", 32'(wd_q[3]), 32'h0F0F);

        // Start and stop together in IDLE
        pulse_stop();
        i_start = 1'b1;
        i_stop  = 1'b1;
        step(1'b1, 1'b0);
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("ss_state", 32'(o_state), 32'(S_IDLE));
        check("ss_recording", 32'(o_recording), 32'h0);
        check("ss_stop_addr", 32'(o_stop_addr), 32'h1);

        // Reset mid-capture
        pulse_start();
        clear_log();
        frame(16'hCAFE, -1, -1, -1);
        check("rc_pre_data", 32'(o_data), 32'hCAFE);
        frame(16'h1111, -1, -1, 10);
        check("rc_count", 32'(wa_q.size()), 32'd1);
        check("rc_state", 32'(o_state), 32'(S_IDLE));
        check("rc_address", 32'(o_address), 32'h0);
        check("rc_data", 32'(o_data), 32'h0);
        check("rc_stop_addr", 32'(o_stop_addr), 32'h0);
        check("rc_recording", 32'(o_recording), 32'h0);
        check("rc_wr_en", 32'(o_wr_en), 32'h0);

        // MAX_ADDR=3: stops after address 3, no wrap
        i_rst = 1'b1;
        step(1'b1, 1'b0);
        i_rst = 1'b0;
        step(1'b1, 1'b0);
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) frame(vecm[i], -1, -1, -1);
        check("mx_count", 32'(ma_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mx_addr%0d", i), 32'(ma_q[i]), 32'(i));
            check($sformatf("mx_data%0d", i), 32'(md_q[i]), 32'(vecm[i]));
        end
        check("mx_stop_addr", 32'(m_stop_addr), 32'h4);
        check("mx_address", 32'(m_address), 32'h3);
        check("mx_state", 32'(m_state), 32'(S_IDLE));
        check("mx_recording", 32'(m_recording), 32'h0);
        check("mx_default_count", 32'(wa_q.size()), 32'd5);
        check("mx_default_stop_addr", 32'(o_stop_addr), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
